// File: rtl/ws2812_driver.sv
// ws2812_driver: serialises a G,R,B colour snapshot to a chain of WS2812 pixels.
// Optional WS2812_AUTO_REFRESH_EN: resend automatically whenever the live colour changes.
module ws2812_driver #(
  parameter int NUM_LEDS     = 1,
  parameter int BIT_CYCLES   = 13,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int RESET_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] level0,
  input  logic [7:0] level1,
  input  logic [7:0] level2,
  input  logic       start,
  output logic       busy,
  output logic       dout
);

  localparam int TMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_BIT  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] T_RST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_0H   = TW'(T0H_CYCLES);
  localparam logic [TW-1:0] T_1H   = TW'(T1H_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, BIT, LATCH} state_e;

  state_e        state_q, state_d;
  logic [23:0]   snap_q, snap_d;
  logic [23:0]   sh_q, sh_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] tmr_nx, th;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic [23:0]   live;
  logic          go;

  assign live = {level1, level0, level2};

`ifdef WS2812_AUTO_REFRESH_EN
  logic [23:0] last_q, last_d;

  assign go = start || (live != last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && go) last_d = live;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  assign go = start;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    tmr_d   = tmr_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    tmr_nx  = tmr_q + T_ONE;
    th      = sh_q[23] ? T_1H : T_0H;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          snap_d  = live;
          sh_d    = live;
          bit_d   = '0;
          pix_d   = '0;
          tmr_d   = '0;
          dout_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = BIT;
        end
      end
      BIT: begin
        if (tmr_q != T_BIT) begin
          tmr_d  = tmr_nx;
          // dout is registered, so decide the level of the next timer value
          dout_d = (tmr_nx < th);
        end else begin
          tmr_d = '0;
          if (bit_q == 5'd23) begin
            if (pix_q == P_LAST) begin
              dout_d  = 1'b0;
              state_d = LATCH;
            end else begin
              sh_d   = snap_q;
              bit_d  = '0;
              pix_d  = pix_q + P_ONE;
              dout_d = 1'b1;
            end
          end else begin
            sh_d   = {sh_q[22:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            dout_d = 1'b1;
          end
        end
      end
      LATCH: begin
        if (tmr_q != T_RST) begin
          tmr_d = tmr_nx;
        end else begin
          tmr_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      tmr_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: directed checks of ws2812_driver bit shapes, frame length and control.
// Two instances: a single pixel chain and a three pixel chain.
module tb_ws2812_driver;

  logic       clk;
  logic       rst_n;
  logic [7:0] lv0, lv1, lv2;
  logic       st1, st3;
  logic       busy1, dout1, busy3, dout3;

  int total = 0;
  int bad   = 0;

  ws2812_driver #(.NUM_LEDS(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .level0(lv0), .level1(lv1), .level2(lv2),
    .start(st1), .busy(busy1), .dout(dout1)
  );

  ws2812_driver #(.NUM_LEDS(3)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .level0(lv0), .level1(lv1), .level2(lv2),
    .start(st3), .busy(busy3), .dout(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe one frame on a chosen instance, optionally pulsing its start first.
  task automatic frame(input bit pulse, input bit three, input int np,
                       input logic [23:0] pat, input string tag);
    int hi [72];
    int n, tail, shape, nb, lim;
    logic d, b;
    logic [71:0] got, exp;
    nb = np * 24;
    lim = nb * 13 + 3000 + 20;
    for (int i = 0; i < 72; i++) hi[i] = 0;
    if (pulse) begin
      @(negedge clk);
      if (three) st3 = 1'b1;
      else st1 = 1'b1;
    end
    @(negedge clk);
    st1 = 1'b0;
    st3 = 1'b0;
    n = 0; tail = 0; shape = 0;
    while (n < lim) begin
      d = three ? dout3 : dout1;
      b = three ? busy3 : busy1;
      if (!b) break;
      if (n < nb * 13) begin
        if (d) begin
          if (hi[n / 13] != n % 13) shape++;
          hi[n / 13]++;
        end
      end else if (d) shape++;
      else tail++;
      n++;
      @(negedge clk);
    end
    got = '0;
    for (int s = 0; s < nb; s++) begin
      got[nb - 1 - s] = (hi[s] == 8);
      if (hi[s] != 8 && hi[s] != 4) shape++;
    end
    exp = (np == 3) ? {pat, pat, pat} : {48'h0, pat};
    check({tag, "_bits"}, got, exp);
    check({tag, "_busy_len"}, n, nb * 13 + 3000);
    check({tag, "_shape"}, shape, 0);
    check({tag, "_latch_low"}, tail, 3000);
    check({tag, "_end_dout"}, three ? dout3 : dout1, 1'b0);
  endtask

  task automatic quiet(input int cyc, input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (busy1 || dout1) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    int n, len, gap;
    rst_n = 1'b0;
    st1 = 1'b0;
    st3 = 1'b0;
    lv0 = 8'hFF;
    lv1 = 8'h00;
    lv2 = 8'h81;
    #23;
    check("rst_dout1", dout1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_dout3", dout3, 1'b0);
    check("rst_busy3", busy3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
    frame(1'b0, 1'b0, 1, 24'h00FF81, "auto");
    quiet(50, "auto_quiet");
    @(negedge clk);
    lv2 = 8'h82;
    frame(1'b0, 1'b0, 1, 24'h00FF82, "auto_chg");
    quiet(50, "auto_once");
`else
    quiet(20, "no_start_idle");
    frame(1'b1, 1'b0, 1, 24'h00FF81, "f1");

    lv0 = 8'hA5; lv1 = 8'hA5; lv2 = 8'hA5;
    frame(1'b1, 1'b1, 3, 24'hA5A5A5, "f3");

    // start held high: back-to-back frames, one idle clock apart
    @(negedge clk);
    st1 = 1'b1;
    n = 0;
    while (!busy1 && n < 5) begin @(negedge clk); n++; end
    check("b2b_rise", n, 1);
    len = 0;
    while (busy1 && len < 4000) begin @(negedge clk); len++; end
    check("b2b_len", len, 3312);
    gap = 0;
    while (!busy1 && gap < 10) begin @(negedge clk); gap++; end
    check("b2b_gap", gap, 1);
    st1 = 1'b0;
    repeat (500) @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    len = 0;
    while (busy1 && len < 4000) begin @(negedge clk); len++; end
    check("b2b_end", busy1, 1'b0);
    quiet(40, "no_extra");

    // level0 changed mid-frame
    lv0 = 8'h12; lv1 = 8'h34; lv2 = 8'h56;
    fork
      frame(1'b1, 1'b0, 1, 24'h341256, "mid");
      begin
        repeat (100) @(negedge clk);
        lv0 = 8'hC3;
      end
    join
    frame(1'b1, 1'b0, 1, 24'h34C356, "next");

    // reset during bit 10 (a 0 bit, still in its high phase)
    @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (133) @(negedge clk);
    check("pre_rst_dout", dout1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout1, 1'b0);
    check("async_rst_busy", busy1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(50, "post_rst_idle");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
